// File: rtl/alu_issue_stage_if.sv
// Bundle of the decode, ALU and writeback signals seen by alu_issue_stage.
// The slave modport is the stage's view; the master modport is the surrounding logic.
interface alu_issue_stage_if #(
    parameter int WIDTH = 16
);
    // Decode side
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_inv;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // ALU side
    logic [2:0]       alu_op;
    logic             alu_inv;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ovfl;
    logic             alu_zero;

    // Writeback side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic             out_ovfl;
    logic             out_zero;
    logic             out_err;

    // Sticky overflow status
    logic             ovfl_sticky;
    logic             ovfl_clr;

    modport slave (
        input  in_valid, in_op, in_inv, in_a, in_b,
        input  alu_r, alu_ovfl, alu_zero,
        input  out_ready, ovfl_clr,
        output in_ready,
        output alu_op, alu_inv, alu_a, alu_b,
        output out_valid, out_r, out_ovfl, out_zero, out_err,
        output ovfl_sticky
    );

    modport master (
        output in_valid, in_op, in_inv, in_a, in_b,
        output alu_r, alu_ovfl, alu_zero,
        output out_ready, ovfl_clr,
        input  in_ready,
        input  alu_op, alu_inv, alu_a, alu_b,
        input  out_valid, out_r, out_ovfl, out_zero, out_err,
        input  ovfl_sticky
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around a combinational ALU: holds operands on the ALU
// for SETTLE_CYCLES cycles, registers the result, and hands it to writeback.
// SETTLE_CYCLES legal range is 1..15 (4-bit settle counter).
module alu_issue_stage #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_stage_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [2:0]       op_reg, op_next;
    logic             inv_reg, inv_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             ovfl_reg, ovfl_next;
    logic             zero_reg, zero_next;
    logic             err_reg, err_next;
    logic             sticky_reg, sticky_next;

    logic             in_ready_c;
    logic             accept;
    logic             op_legal;
    logic [WIDTH-1:0] r_masked;

    // Ops 4..7 have bit 2 set; their ALU result is replaced by zero at capture.
    assign op_legal = ~op_reg[2];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rmask
            assign r_masked[gi] = io.alu_r[gi] & op_legal;
        end
    endgenerate

    // Next-state, handshake and capture logic for the IDLE/EXEC/HOLD machine.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        inv_next    = inv_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        valid_next  = valid_reg;
        r_next      = r_reg;
        ovfl_next   = ovfl_reg;
        zero_next   = zero_reg;
        err_next    = err_reg;
        sticky_next = sticky_reg;
        in_ready_c  = 1'b0;

        // Clear first so that a capture with overflow in the same cycle wins.
        if (io.ovfl_clr) begin
            sticky_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
            end
            EXEC: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    r_next     = r_masked;
                    ovfl_next  = io.alu_ovfl & op_legal;
                    zero_next  = io.alu_zero | ~op_legal;
                    err_next   = ~op_legal;
                    valid_next = 1'b1;
                    state_next = HOLD;
                    if (io.alu_ovfl && op_legal) begin
                        sticky_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Consuming the result frees the stage in the same cycle.
                in_ready_c = io.out_ready;
                if (io.out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        accept = io.in_valid & in_ready_c;
        if (accept) begin
            op_next    = io.in_op;
            inv_next   = io.in_inv;
            a_next     = io.in_a;
            b_next     = io.in_b;
            cnt_next   = CNT_LOAD;
            state_next = EXEC;
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            op_reg     <= 3'd0;
            inv_reg    <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            valid_reg  <= 1'b0;
            r_reg      <= '0;
            ovfl_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            inv_reg    <= inv_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            valid_reg  <= valid_next;
            r_reg      <= r_next;
            ovfl_reg   <= ovfl_next;
            zero_reg   <= zero_next;
            err_reg    <= err_next;
            sticky_reg <= sticky_next;
        end
    end

    assign io.in_ready    = in_ready_c;
    assign io.alu_op      = op_reg;
    assign io.alu_inv     = inv_reg;
    assign io.alu_a       = a_reg;
    assign io.alu_b       = b_reg;
    assign io.out_valid   = valid_reg;
    assign io.out_r       = r_reg;
    assign io.out_ovfl    = ovfl_reg;
    assign io.out_zero    = zero_reg;
    assign io.out_err     = err_reg;
    assign io.ovfl_sticky = sticky_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with SETTLE_CYCLES=2 and a behavioural 16-bit ALU.
// Expected results are queued when an operation is issued and popped when
// the stage presents a result.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [15:0] r;
        logic        ovfl;
        logic        zero;
        logic        err;
    } res_t;

    logic clk;
    logic rst_n;
    res_t sb[$];
    res_t exp_res;
    int   checks;
    int   passed;

    alu_issue_stage_if #(.WIDTH(16)) bus ();

    alu_issue_stage #(
        .WIDTH(16),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    // ALU model: AND, OR, ADD (ovfl = carry out), signed SLT; illegal ops
    // return a deliberately nonzero result with ovfl set.
    logic [15:0] alu_bb;
    logic [16:0] alu_sum;
    always_comb begin
        alu_bb       = bus.alu_inv ? ~bus.alu_b : bus.alu_b;
        alu_sum      = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {16'd0, bus.alu_inv};
        bus.alu_ovfl = 1'b0;
        case (bus.alu_op)
            3'd0:    bus.alu_r = bus.alu_a & alu_bb;
            3'd1:    bus.alu_r = bus.alu_a | alu_bb;
            3'd2:    begin bus.alu_r = alu_sum[15:0]; bus.alu_ovfl = alu_sum[16]; end
            3'd3:    bus.alu_r = {15'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            default: begin bus.alu_r = bus.alu_a ^ bus.alu_b; bus.alu_ovfl = 1'b1; end
        endcase
        bus.alu_zero = (bus.alu_r == 16'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one operation at a negedge once in_ready is seen; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic inv, input logic [15:0] a, input logic [15:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            $display("FAIL issue_timeout: in_ready got 0 required 1");
            $fatal(1, "issue timeout");
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_inv   = inv;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Advance to the first negedge with out_valid=1.
    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            $display("FAIL result_timeout: out_valid got 0 required 1");
            $fatal(1, "result timeout");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_inv = 1'b0;
        bus.in_a = 16'd0; bus.in_b = 16'd0;
        bus.out_ready = 1'b0; bus.ovfl_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else passed++;
        checks++; if (bus.out_r !== 16'd0) $display("FAIL rst_out_r got %h exp 0000", bus.out_r); else passed++;
        checks++; if ({bus.out_ovfl, bus.out_zero, bus.out_err} !== 3'b000)
            $display("FAIL rst_out_flags got %b exp 000", {bus.out_ovfl, bus.out_zero, bus.out_err}); else passed++;
        checks++; if (bus.ovfl_sticky !== 1'b0) $display("FAIL rst_sticky got %b exp 0", bus.ovfl_sticky); else passed++;
        checks++; if ({bus.alu_op, bus.alu_inv, bus.alu_a, bus.alu_b} !== 36'd0)
            $display("FAIL rst_alu_regs got %h exp 0", {bus.alu_op, bus.alu_inv, bus.alu_a, bus.alu_b}); else passed++;
    endtask

    task automatic test_and_latency();
        bus.out_ready = 1'b1;
        sb.push_back('{r: 16'h0001, ovfl: 1'b0, zero: 1'b0, err: 1'b0});
        issue(3'd0, 1'b0, 16'hFFFF, 16'h0001);
        @(negedge clk); // between edges t and t+1
        @(negedge clk); // after edge t+1
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL and_early_valid got %b exp 0", bus.out_valid); else passed++;
        @(negedge clk); // after edge t+2
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL and_latency_valid got %b exp 1", bus.out_valid); else passed++;
        exp_res = sb.pop_front();
        $display("txn and: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL and_result got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        @(negedge clk); // consumed at the intervening edge
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL and_drop_valid got %b exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_add_sticky();
        bus.out_ready = 1'b1;
        sb.push_back('{r: 16'h0000, ovfl: 1'b1, zero: 1'b1, err: 1'b0});
        issue(3'd2, 1'b0, 16'hFFFF, 16'h0001);
        wait_valid();
        exp_res = sb.pop_front();
        $display("txn add: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL add_result got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        checks++; if (bus.ovfl_sticky !== 1'b1) $display("FAIL add_sticky_set got %b exp 1", bus.ovfl_sticky); else passed++;
        @(negedge clk);
        checks++; if (bus.ovfl_sticky !== 1'b1) $display("FAIL add_sticky_hold got %b exp 1", bus.ovfl_sticky); else passed++;
        bus.ovfl_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovfl_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.ovfl_sticky !== 1'b0) $display("FAIL add_sticky_clr got %b exp 0", bus.ovfl_sticky); else passed++;

        // Clear held high across a capture with overflow: the set must win.
        bus.ovfl_clr = 1'b1;
        sb.push_back('{r: 16'h0000, ovfl: 1'b1, zero: 1'b1, err: 1'b0});
        issue(3'd2, 1'b0, 16'h8000, 16'h8000);
        wait_valid();
        exp_res = sb.pop_front();
        $display("txn add2: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL add2_result got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        checks++; if (bus.ovfl_sticky !== 1'b1) $display("FAIL set_wins_sticky got %b exp 1", bus.ovfl_sticky); else passed++;
        @(posedge clk); #1;
        bus.ovfl_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.ovfl_sticky !== 1'b0) $display("FAIL set_wins_then_clr got %b exp 0", bus.ovfl_sticky); else passed++;
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        sb.push_back('{r: 16'hFFFF, ovfl: 1'b0, zero: 1'b0, err: 1'b0});
        issue(3'd1, 1'b0, 16'hFFFF, 16'h0001);
        wait_valid();
        exp_res = sb.pop_front();
        $display("txn or: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.out_valid, bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== {1'b1, exp_res})
                $display("FAIL stall_hold[%0d] got %h exp %h", i, {bus.out_valid, bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, {1'b1, exp_res}); else passed++;
            checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus.in_ready); else passed++;
            @(negedge clk);
        end
        // Release with a new op already pending: accepted on the same edge.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_inv = 1'b0;
        bus.in_a = 16'h00F0; bus.in_b = 16'h0FF0;
        sb.push_back('{r: 16'h00F0, ovfl: 1'b0, zero: 1'b0, err: 1'b0});
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", bus.in_ready); else passed++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00)
            $display("FAIL release_exec got valid,ready=%b exp 00", {bus.out_valid, bus.in_ready}); else passed++;
        checks++; if (bus.alu_a !== 16'h00F0) $display("FAIL release_alu_a got %h exp 00f0", bus.alu_a); else passed++;
        wait_valid();
        exp_res = sb.pop_front();
        $display("txn and2: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL release_result got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        sb.push_back('{r: 16'h0000, ovfl: 1'b0, zero: 1'b1, err: 1'b0}); // 1 < -1 is false
        sb.push_back('{r: 16'h0001, ovfl: 1'b0, zero: 1'b0, err: 1'b0}); // -1 < 1 is true
        issue(3'd3, 1'b1, 16'h0001, 16'hFFFF);
        bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_inv = 1'b1;
        bus.in_a = 16'hFFFF; bus.in_b = 16'h0001;
        @(negedge clk); // after t
        @(negedge clk); // after t+1
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00)
            $display("FAIL b2b_exec1 got valid,ready=%b exp 00", {bus.out_valid, bus.in_ready}); else passed++;
        @(negedge clk); // after t+2
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b11)
            $display("FAIL b2b_hold1 got valid,ready=%b exp 11", {bus.out_valid, bus.in_ready}); else passed++;
        exp_res = sb.pop_front();
        $display("txn slt1: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL b2b_result1 got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        @(posedge clk); #1; // t+3: result 1 consumed and op 2 accepted
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00)
            $display("FAIL b2b_no_idle got valid,ready=%b exp 00", {bus.out_valid, bus.in_ready}); else passed++;
        checks++; if (bus.alu_a !== 16'hFFFF) $display("FAIL b2b_alu_a got %h exp ffff", bus.alu_a); else passed++;
        @(negedge clk); // after t+4
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_exec2 got %b exp 0", bus.out_valid); else passed++;
        @(negedge clk); // after t+5
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_latency2 got %b exp 1", bus.out_valid); else passed++;
        exp_res = sb.pop_front();
        $display("txn slt2: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL b2b_result2 got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        @(negedge clk);
    endtask

    task automatic test_illegal_and_reset();
        bus.out_ready = 1'b1;
        sb.push_back('{r: 16'h0000, ovfl: 1'b0, zero: 1'b1, err: 1'b1});
        issue(3'd5, 1'b0, 16'h1234, 16'h00FF);
        wait_valid();
        exp_res = sb.pop_front();
        $display("txn illegal: r=%h ovfl=%b zero=%b err=%b", bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err);
        checks++; if ({bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err} !== exp_res)
            $display("FAIL illegal_result got %h exp %h", {bus.out_r, bus.out_ovfl, bus.out_zero, bus.out_err}, exp_res); else passed++;
        checks++; if (bus.ovfl_sticky !== 1'b0) $display("FAIL illegal_sticky got %b exp 0", bus.ovfl_sticky); else passed++;
        @(negedge clk);

        // Reset during EXEC: the overflowing ADD must never surface.
        issue(3'd2, 1'b0, 16'hFFFF, 16'h0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL midrst_async got valid,ready=%b exp 01", {bus.out_valid, bus.in_ready}); else passed++;
        checks++; if (bus.alu_a !== 16'd0) $display("FAIL midrst_alu_a got %h exp 0000", bus.alu_a); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bus.out_valid, bus.in_ready, bus.ovfl_sticky} !== 3'b010)
                $display("FAIL midrst_idle[%0d] got valid,ready,sticky=%b exp 010", i, {bus.out_valid, bus.in_ready, bus.ovfl_sticky}); else passed++;
        end
        checks++; if (sb.size() !== 0) $display("FAIL scoreboard_empty got %0d exp 0", sb.size()); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_and_latency();
        test_add_sticky();
        test_stall();
        test_back_to_back();
        test_illegal_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
